// File: rtl/fifo_ptr_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ptr_pkg
// Shared helpers for the async FIFO pointer controllers (wr_ptr_ctrl and
// rd_ptr_ctrl): binary/Gray conversion and the pointer-width derivation.
// The conversions work on a 32-bit container; callers zero-extend their
// pointer in and truncate the result back to their own width. Zero-extension
// is transparent to both conversions, so the result is exact for any
// pointer width up to 32.
// -----------------------------------------------------------------------------
package fifo_ptr_pkg;

    // Pointer width: one extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_w(input int addr_width);
        return addr_width + 32'sd1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 32'd1);
    endfunction

    // Prefix XOR from the MSB down.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int i = 32'sd30; i >= 32'sd0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/wr_ptr_ctrl_if.sv
// -----------------------------------------------------------------------------
// wr_ptr_ctrl_if
// Bundle between the write-domain producer side and wr_ptr_ctrl.
//   wr_en         producer write request
//   rd_gray_sync  read Gray pointer, already synchronised into the write clock
//   wr_fire       memory write enable
//   wr_addr       memory write address
//   wr_gray       registered Gray write pointer for the read domain
//   full          registered full flag
//   overflow      sticky write-while-full error
//   almost_full   only with WR_ALMOST_FULL_EN
//   wr_level      only with WR_ALMOST_FULL_EN
// modport master: producer/environment side; modport slave: wr_ptr_ctrl.
// -----------------------------------------------------------------------------
interface wr_ptr_ctrl_if
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
);
    localparam int PTR_W = ptr_w(ADDR_WIDTH);

    logic                  wr_en;
    logic [PTR_W-1:0]      rd_gray_sync;
    logic                  wr_fire;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [PTR_W-1:0]      wr_gray;
    logic                  full;
    logic                  overflow;
`ifdef WR_ALMOST_FULL_EN
    logic                  almost_full;
    logic [PTR_W-1:0]      wr_level;

    modport master (
        output wr_en, rd_gray_sync,
        input  wr_fire, wr_addr, wr_gray, full, overflow, almost_full, wr_level
    );
    modport slave (
        input  wr_en, rd_gray_sync,
        output wr_fire, wr_addr, wr_gray, full, overflow, almost_full, wr_level
    );
`else
    modport master (
        output wr_en, rd_gray_sync,
        input  wr_fire, wr_addr, wr_gray, full, overflow
    );
    modport slave (
        input  wr_en, rd_gray_sync,
        output wr_fire, wr_addr, wr_gray, full, overflow
    );
`endif
endinterface

// File: rtl/gray_ptr_counter.sv
// -----------------------------------------------------------------------------
// gray_ptr_counter
// Binary + Gray pointer pair shared by the FIFO write and read controllers.
//   clk, rst   clock, asynchronous active-high reset
//   inc        advance the pointer by one this edge
//   bin, gray  registered pointers (gray comes straight from a flop)
//   bin_next, gray_next  combinational next-state values
// -----------------------------------------------------------------------------
module gray_ptr_counter
    import fifo_ptr_pkg::*;
#(
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] bin,
    output logic [PTR_W-1:0] gray,
    output logic [PTR_W-1:0] bin_next,
    output logic [PTR_W-1:0] gray_next
);
    logic [PTR_W-1:0] bin_q;
    logic [PTR_W-1:0] gray_q;

    // Next-state pointers; the binary add wraps naturally at 2**PTR_W.
    always_comb begin
        bin_next  = bin_q + {{(PTR_W-1){1'b0}}, inc};
        gray_next = PTR_W'(bin2gray(32'(bin_next)));
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= {PTR_W{1'b0}};
            gray_q <= {PTR_W{1'b0}};
        end else begin
            bin_q  <= bin_next;
            gray_q <= gray_next;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
endmodule

// File: rtl/wr_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// wr_ptr_ctrl
// Write-domain pointer/flag controller of the async FIFO.
//   clk   write-domain clock
//   rst   asynchronous active-high reset
//   bus   wr_ptr_ctrl_if.slave: wr_en, rd_gray_sync in; wr_fire, wr_addr,
//         wr_gray, full, overflow (and almost_full, wr_level) out
// Optional feature macro: WR_ALMOST_FULL_EN adds the AF_THRESH parameter and
// the almost_full / wr_level outputs.
// -----------------------------------------------------------------------------
module wr_ptr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
`ifdef WR_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH  = 12
`endif
) (
    input  logic          clk,
    input  logic          rst,
    wr_ptr_ctrl_if.slave  bus
);
    localparam int PTR_W = ptr_w(ADDR_WIDTH);

    logic [PTR_W-1:0] wr_bin_s;
    logic [PTR_W-1:0] wr_gray_s;
    logic [PTR_W-1:0] bin_next_s;
    logic [PTR_W-1:0] gray_next_s;
    logic [PTR_W-1:0] full_cmp_s;
    logic             wr_fire_s;
    logic             full_q;
    logic             full_d;
    logic             overflow_q;
    logic             overflow_d;

    // A write is accepted only when the registered flag says there is room;
    // a slot freed on this very cycle is not seen until the flag updates.
    assign wr_fire_s = bus.wr_en & ~full_q;

    gray_ptr_counter #(
        .PTR_W     (PTR_W)
    ) u_wr_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (wr_fire_s),
        .bin       (wr_bin_s),
        .gray      (wr_gray_s),
        .bin_next  (bin_next_s),
        .gray_next (gray_next_s)
    );

    // Full when the next write pointer is exactly one lap ahead of the read
    // pointer; in Gray code that is the read pointer with its top two bits inverted.
    always_comb begin
        full_cmp_s = {~bus.rd_gray_sync[PTR_W-1:PTR_W-2], bus.rd_gray_sync[PTR_W-3:0]};
        full_d     = (gray_next_s == full_cmp_s);
        overflow_d = overflow_q | (bus.wr_en & full_q);
    end

    // Full and sticky overflow flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.wr_fire  = wr_fire_s;
    assign bus.wr_addr  = wr_bin_s[ADDR_WIDTH-1:0];
    assign bus.wr_gray  = wr_gray_s;
    assign bus.full     = full_q;
    assign bus.overflow = overflow_q;

`ifdef WR_ALMOST_FULL_EN
    localparam logic [PTR_W-1:0] AF_T = PTR_W'(AF_THRESH);

    logic [PTR_W-1:0] rd_bin_s;
    logic [PTR_W-1:0] level_d;
    logic [PTR_W-1:0] level_q;
    logic             almost_full_d;
    logic             almost_full_q;
    logic             unused_bits_s;

    // Fill level from the (stale) synchronised read pointer: never under-reports.
    always_comb begin
        rd_bin_s      = PTR_W'(gray2bin(32'(bus.rd_gray_sync)));
        level_d       = bin_next_s - rd_bin_s;
        almost_full_d = (level_d >= AF_T);
    end

    // Level and almost-full registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q       <= {PTR_W{1'b0}};
            almost_full_q <= 1'b0;
        end else begin
            level_q       <= level_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign bus.wr_level    = level_q;
    assign bus.almost_full = almost_full_q;
    assign unused_bits_s   = wr_bin_s[PTR_W-1];
`else
    logic unused_bits_s;
    assign unused_bits_s = ^{wr_bin_s[PTR_W-1], bin_next_s};
`endif
endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wr_ptr_ctrl
// Self-checking bench for wr_ptr_ctrl (ADDR_WIDTH=4, depth 16). A write/read
// count model predicts all outputs each cycle; directed steps pin the model
// with literal expectations.
// -----------------------------------------------------------------------------
module tb_wr_ptr_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en_b = 1'b0;
    int   rd_cnt = 0;
    int   checks = 0;
    int   failures = 0;

    // Model state: total accepted writes and flag values.
    int   m_wc = 0;
    int   m_fire;
    logic m_full = 1'b0;
    logic m_ovf = 1'b0;
    int   m_level = 0;
    logic m_af = 1'b0;

    wr_ptr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

`ifdef WR_ALMOST_FULL_EN
    wr_ptr_ctrl #(.ADDR_WIDTH(4), .AF_THRESH(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`else
    wr_ptr_ctrl #(.ADDR_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`endif

    always #5 clk = ~clk;

    function automatic logic [4:0] g5(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    function automatic int occ(input int w, input int r);
        return (w - r) & 31;
    endfunction

    assign bus.wr_en        = wr_en_b;
    assign bus.rd_gray_sync = g5(rd_cnt);
    assign m_fire           = (wr_en_b && !m_full) ? 1 : 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: full means the writer is a whole lap (16 entries) ahead of the reader.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wc    <= 0;
            m_full  <= 1'b0;
            m_ovf   <= 1'b0;
            m_level <= 0;
            m_af    <= 1'b0;
        end else begin
            m_wc    <= m_wc + m_fire;
            m_full  <= (occ(m_wc + m_fire, rd_cnt) == 16);
            m_ovf   <= m_ovf || (wr_en_b && m_full);
            m_level <= occ(m_wc + m_fire, rd_cnt);
            m_af    <= (occ(m_wc + m_fire, rd_cnt) >= 12);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc_fire",  32'(bus.wr_fire),  32'(m_fire));
        chk("cyc_addr",  32'(bus.wr_addr),  32'(m_wc & 15));
        chk("cyc_gray",  32'(bus.wr_gray),  32'(g5(m_wc)));
        chk("cyc_full",  32'(bus.full),     32'(m_full));
        chk("cyc_ovf",   32'(bus.overflow), 32'(m_ovf));
`ifdef WR_ALMOST_FULL_EN
        chk("cyc_level", 32'(bus.wr_level),    32'(m_level));
        chk("cyc_af",    32'(bus.almost_full), 32'(m_af));
`endif
    end

    task automatic step(input logic en);
        wr_en_b = en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] exp_g [5];
        logic [4:0] prev;
        exp_g[0] = 5'b00001; exp_g[1] = 5'b00011; exp_g[2] = 5'b00010;
        exp_g[3] = 5'b00110; exp_g[4] = 5'b00111;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_gray", 32'(bus.wr_gray), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);

        // Asynchronous reset mid-stream after 5 writes.
        for (int i = 0; i < 5; i++) step(1'b1);
        chk("pre_rst_addr", 32'(bus.wr_addr), 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("arst_gray", 32'(bus.wr_gray), 32'd0);
        chk("arst_addr", 32'(bus.wr_addr), 32'd0);
        chk("arst_full", 32'(bus.full), 32'd0);
        chk("arst_ovf",  32'(bus.overflow), 32'd0);
        wr_en_b = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill from empty with the read pointer at 0.
        for (int k = 1; k <= 16; k++) begin
            step(1'b1);
            if (k <= 5) chk("fill_gray_seq", 32'(bus.wr_gray), 32'(exp_g[k-1]));
            if (k == 15) chk("fill_not_full_15", 32'(bus.full), 32'd0);
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_gray", 32'(bus.wr_gray), 32'(5'b11000));

        // Writes while full are dropped and flag overflow.
        step(1'b1);
        chk("ovf_fire", 32'(bus.wr_fire), 32'd0);
        chk("ovf_set",  32'(bus.overflow), 32'd1);
        step(1'b1);
        chk("ovf_gray", 32'(bus.wr_gray), 32'(5'b11000));
        step(1'b0);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Free one slot.
        rd_cnt = 1;
        step(1'b0);
        chk("free_full", 32'(bus.full), 32'd0);
        chk("free_addr", 32'(bus.wr_addr), 32'd0);
        step(1'b1);
        chk("refill_full", 32'(bus.full), 32'd1);
        chk("refill_gray", 32'(bus.wr_gray), 32'(5'b11001));

        // Slot freed on the same cycle as a write attempt: write rejected.
        rd_cnt = 2;
        step(1'b1);
        chk("race_gray", 32'(bus.wr_gray), 32'(5'b11001));
        chk("race_full", 32'(bus.full), 32'd0);
        step(1'b1);
        chk("retry_full", 32'(bus.full), 32'd1);
        chk("retry_addr", 32'(bus.wr_addr), 32'd2);

        // Drain, then 40 writes with the reader keeping pace; pointer wraps.
        rd_cnt = 18;
        step(1'b0);
        for (int i = 0; i < 40; i++) begin
            prev = bus.wr_gray;
            rd_cnt = rd_cnt + 1;
            step(1'b1);
            chk("wrap_onebit", 32'($countones(prev ^ bus.wr_gray)), 32'd1);
            chk("wrap_nofull", 32'(bus.full), 32'd0);
        end
        chk("wrap_gray", 32'(bus.wr_gray), 32'(5'b10111));
        chk("wrap_addr", 32'(bus.wr_addr), 32'd10);

`ifdef WR_ALMOST_FULL_EN
        wr_en_b = 1'b0;
        #2 rst = 1'b1;
        rd_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 11; i++) step(1'b1);
        chk("af_level_11", 32'(bus.wr_level), 32'd11);
        chk("af_off_11",   32'(bus.almost_full), 32'd0);
        step(1'b1);
        chk("af_level_12", 32'(bus.wr_level), 32'd12);
        chk("af_on_12",    32'(bus.almost_full), 32'd1);
`endif

        step(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wr_ptr_ctrl.md
Name: wr_ptr_ctrl

Overview:
- Write-domain pointer/flag controller for the async FIFO. Mirror of rd_ptr_ctrl.
- Keeps the binary and Gray write pointers and drives the memory write address/enable.
- Publishes a registered Gray write pointer; the read domain's sync_gray instance consumes it.
- Consumes the read Gray pointer after it has been synchronised into this domain by sync_gray, and generates a registered full flag.

Parameters:
- ADDR_WIDTH, 4, FIFO address width; depth = 2**ADDR_WIDTH; pointer width PTR_W = ADDR_WIDTH+1 (5 by default, matching sync_gray WIDTH).
- AF_THRESH, 12, almost-full level in entries; used only with WR_ALMOST_FULL_EN; legal range 1..2**ADDR_WIDTH.

Ports:
- clk  input  1  write-domain clock.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request from the producer.
- rd_gray_sync  input  PTR_W  read Gray pointer, already 2-FF synchronised into clk (sync_gray output).
- wr_fire  output  1  memory write enable, combinational: wr_en & ~full.
- wr_addr  output  ADDR_WIDTH  memory write address = wr_bin[ADDR_WIDTH-1:0].
- wr_gray  output  PTR_W  registered Gray write pointer, to the read-domain sync_gray.
- full  output  1  registered FIFO-full flag.
- overflow  output  1  sticky error: write attempted while full.
- almost_full  output  1  only with WR_ALMOST_FULL_EN.
- wr_level  output  PTR_W  only with WR_ALMOST_FULL_EN; fill count, 0..2**ADDR_WIDTH.

Behaviour:
- Reset (async assert, released synchronously by the system): wr_bin=0, wr_gray=0, full=0, overflow=0, almost_full=0, wr_level=0.
- Reset mid-operation clears all state immediately; pointer contents are not preserved.
- Next-state terms:
  - bin_next = wr_bin + wr_fire, modulo 2**PTR_W; wraps from 2**PTR_W-1 to 0.
  - gray_next = bin_next ^ (bin_next >> 1).
- On every clk edge: wr_bin <= bin_next, wr_gray <= gray_next.
- wr_gray must come straight from a flop; no combinational logic between that register and the output, so the CDC path stays glitch-free.
- Full compare, registered: full <= (gray_next == {~rd_gray_sync[PTR_W-1:PTR_W-2], rd_gray_sync[PTR_W-3:0]}).
  - full asserts on the same edge that accepts the write filling the last slot; zero-cycle latency as seen by the producer.
  - full deasserts one clk after rd_gray_sync advances, i.e. 3+ write clocks after the real read. Conservative by design.
- wr_en while full:
  - No write: wr_fire=0 and pointers hold.
  - overflow <= 1 and stays set until rst.
- wr_en=1 on the same cycle that rd_gray_sync frees a slot while full is still 1: the write is rejected. The producer retries next cycle.
- The synchronised read pointer only moves forward. Any Gray value is accepted as input; the block never checks rd_gray_sync for consistency.
- wr_addr follows wr_bin combinationally. The memory captures the data at wr_addr on the clk edge where wr_fire=1.

Optional Feature:
- Macro: WR_ALMOST_FULL_EN.
- Defined:
  - rd_bin = gray2bin(rd_gray_sync).
  - wr_level <= bin_next - rd_bin, modulo 2**PTR_W (registered).
  - almost_full <= (bin_next - rd_bin) >= AF_THRESH (registered).
  - Both are pessimistic by the sync latency.
- Not defined: the almost_full and wr_level ports and all associated logic are absent; the rest of the block is unchanged.

Decomposition:
- Shared package fifo_ptr_pkg holds the functions bin2gray(x) and gray2bin(x) (parameterised-width, used by rd_ptr_ctrl too) and a PTR_W derivation constant function.
- One natural sub-module: gray_ptr_counter.
  - Parameter PTR_W; inputs clk, rst, inc.
  - Outputs registered bin and gray, plus combinational bin_next and gray_next.
  - Shared with rd_ptr_ctrl.
- The full compare stays in wr_ptr_ctrl.

Test Plan (ADDR_WIDTH=4, depth 16):
- Reset check: assert rst mid-stream after 5 writes -> wr_gray=0, wr_addr=0, full=0, overflow=0 asynchronously, before the next clk.
- Fill: rd_gray_sync held at 0, wr_en=1 for 16 cycles -> wr_addr 0..15, wr_gray follows the Gray sequence 00,01,03,02,06..., full=1 on the edge of the 16th write, wr_gray=5'b11000.
- Overflow: continue wr_en=1 for 2 more cycles while full -> wr_fire=0, wr_gray stays 5'b11000, overflow=1 and stays 1.
- Free a slot: drive rd_gray_sync=5'b00001 -> full=0 one clk later; the next write goes to wr_addr=0 and full=1 again.
- Wrap-around: 40 writes interleaved with matching rd_gray_sync advances -> the binary pointer wraps 31->0, wr_gray changes exactly one bit per increment, full never spuriously set.
- WR_ALMOST_FULL_EN with AF_THRESH=12: 11 writes from empty -> almost_full=0, wr_level=11; 12th write -> almost_full=1, wr_level=12.
